// File: rtl/mult_seq_if.sv
// Request/result bundle for the sequential shift-add multiplier.
// The master drives the operands and start; the slave returns the product and status.
interface mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] prod_lo;
   logic [WIDTH-1:0] prod_hi;
   logic             busy;
   logic             done;

   modport master (
      output start,
      output is_signed,
      output a,
      output b,
      input  prod_lo,
      input  prod_hi,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  is_signed,
      input  a,
      input  b,
      output prod_lo,
      output prod_hi,
      output busy,
      output done
   );
endinterface

// File: rtl/mult_seq.sv
// Sequential WIDTH x WIDTH multiplier: one shift-add step per cycle on magnitudes,
// with the sign applied once at the end. Signed and unsigned operands are supported.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | WIDTH shift-add iterations, one per cycle
// FIX   | apply the sign to the 2*WIDTH-bit result and load the product registers
// DONE  | one-cycle done pulse, then back to IDLE
module mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   mult_seq_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
   logic [WIDTH-1:0] prod_hi_q, prod_hi_d;

   logic [WIDTH:0]   sum;
   logic [2*WIDTH-1:0] full;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   // Magnitudes stay unsigned so the most-negative operand maps to 2^(WIDTH-1).
   always_comb begin
      mag_a = bus.a;
      mag_b = bus.b;
      if (bus.is_signed && bus.a[WIDTH-1]) begin
         mag_a = (~bus.a) + WIDTH'(1);
      end
      if (bus.is_signed && bus.b[WIDTH-1]) begin
         mag_b = (~bus.b) + WIDTH'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mplier_d  = mplier_q;
      neg_d     = neg_q;
      prod_lo_d = prod_lo_q;
      prod_hi_d = prod_hi_q;
      sum       = '0;
      full      = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_RUN;
               mcand_d  = mag_a;
               mplier_d = mag_b;
               neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
            end
         end

         S_RUN: begin
            // The carry out of the add shifts straight back into the accumulator MSB.
            sum      = {1'b0, acc_q} + ({(WIDTH+1){mplier_q[0]}} & {1'b0, mcand_q});
            acc_d    = sum[WIDTH:1];
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            full = {acc_q, mplier_q};
            if (neg_q) begin
               full = (~full) + (2*WIDTH)'(1);
            end
            prod_hi_d = full[2*WIDTH-1:WIDTH];
            prod_lo_d = full[WIDTH-1:0];
            state_d   = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         mplier_q  <= '0;
         neg_q     <= 1'b0;
         prod_lo_q <= '0;
         prod_hi_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mplier_q  <= mplier_d;
         neg_q     <= neg_d;
         prod_lo_q <= prod_lo_d;
         prod_hi_q <= prod_hi_d;
      end
   end

   assign bus.busy    = (state_q == S_RUN) || (state_q == S_FIX);
   assign bus.done    = (state_q == S_DONE);
   assign bus.prod_lo = prod_lo_q;
   assign bus.prod_hi = prod_hi_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed corner vectors plus random operands, checked against
// an arithmetic reference product; also covers busy interaction, held start and reset abort.
module tb_mult_seq;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic [63:0] last_prod;

   mult_seq_if #(.WIDTH(32)) bus ();

   mult_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
      longint          sx, sy;
      longint unsigned ux, uy;
      if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      ux = {32'd0, x};
      uy = {32'd0, y};
      return 64'(ux * uy);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation: accept edge, then 40 samples; done expected 33 edges after accept.
   // poke >= 0 pulses start with unrelated operands after that sample.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                        input int poke);
      logic [63:0] exp;
      int busy_n;
      int done_n;
      int done_at;
      exp = model(av, bv, sv);
      bus.start     = 1'b1;
      bus.a         = av;
      bus.b         = bv;
      bus.is_signed = sv;
      tick();
      bus.start     = 1'b0;
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.is_signed = 1'($urandom);
      check("prod_hold_on_start", {bus.prod_hi, bus.prod_lo}, last_prod);
      busy_n  = 0;
      done_n  = 0;
      done_at = -1;
      for (int e = 0; e < 40; e++) begin
         if (e > 0) tick();
         if (bus.busy) busy_n++;
         if (bus.done) begin
            done_n++;
            if (done_at < 0) done_at = e;
         end
         if (e == poke) begin
            bus.start     = 1'b1;
            bus.a         = $urandom;
            bus.b         = $urandom;
            bus.is_signed = 1'($urandom);
         end else begin
            bus.start = 1'b0;
         end
      end
      check("done_latency", 64'(done_at), 64'd33);
      check("busy_cycles", 64'(busy_n), 64'd33);
      check("done_pulses", 64'(done_n), 64'd1);
      check("product", {bus.prod_hi, bus.prod_lo}, exp);
      last_prod = exp;
   endtask

   initial begin
      int          done_n;
      int          busy_n;
      int          d1, d2;
      logic [31:0] ra, rb;
      checks        = 0;
      failures      = 0;
      last_prod     = '0;
      reset         = 1'b1;
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.a         = 32'd5;
      bus.b         = 32'd5;
      repeat (3) tick();
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
      bus.start = 1'b0;
      reset     = 1'b0;

      // First start accepted on the first edge after reset release.
      do_op(32'd7, 32'd6, 1'b0, -1);
      check("vec_7x6", {bus.prod_hi, bus.prod_lo}, 64'h0000_0000_0000_002A);
      do_op(32'hFFFF_FFFD, 32'd5, 1'b1, -1);
      check("vec_m3x5", {bus.prod_hi, bus.prod_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
      check("vec_umax", {bus.prod_hi, bus.prod_lo}, 64'hFFFF_FFFE_0000_0001);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1);
      check("vec_sm1", {bus.prod_hi, bus.prod_lo}, 64'h0000_0000_0000_0001);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1);
      check("vec_minmin", {bus.prod_hi, bus.prod_lo}, 64'h4000_0000_0000_0000);
      do_op(32'h8000_0000, 32'd1, 1'b1, -1);
      check("vec_minx1", {bus.prod_hi, bus.prod_lo}, 64'hFFFF_FFFF_8000_0000);
      do_op(32'd0, 32'hDEAD_BEEF, 1'b1, -1);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b0, -1);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'd0;
            default: ;
         endcase
         do_op(ra, rb, 1'($urandom), -1);
      end

      // Start pulsed mid-operation must be ignored.
      do_op(32'd3, 32'd4, 1'b0, 10);
      check("vec_busy_3x4", {bus.prod_hi, bus.prod_lo}, 64'd12);

      // Start held high: back-to-back operations, second operands set after first done.
      bus.start     = 1'b1;
      bus.a         = 32'd5;
      bus.b         = 32'hFFFF_FFF7;
      bus.is_signed = 1'b1;
      tick();
      d1 = -1;
      d2 = -1;
      for (int e = 0; e < 76; e++) begin
         if (e > 0) tick();
         if (bus.done) begin
            if (d1 < 0) d1 = e;
            else if (d2 < 0) d2 = e;
         end
         if (e == 34) check("b2b_prod1", {bus.prod_hi, bus.prod_lo}, model(32'd5, 32'hFFFF_FFF7, 1'b1));
         if (bus.done && d2 < 0) begin
            bus.a         = 32'h1234_5678;
            bus.b         = 32'h9ABC_DEF0;
            bus.is_signed = 1'b0;
         end
         if (d2 >= 0) bus.start = 1'b0;
      end
      bus.start = 1'b0;
      check("b2b_done1", 64'(d1), 64'd33);
      check("b2b_done2", 64'(d2), 64'd68);
      last_prod = model(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      check("b2b_prod2", {bus.prod_hi, bus.prod_lo}, last_prod);
      repeat (3) tick();

      // Reset during RUN aborts with no done pulse and clears the outputs.
      bus.start     = 1'b1;
      bus.a         = 32'd9;
      bus.b         = 32'd11;
      bus.is_signed = 1'b0;
      tick();
      bus.start = 1'b0;
      done_n    = 0;
      busy_n    = 0;
      for (int e = 0; e < 50; e++) begin
         if (e > 0) tick();
         if (bus.done) done_n++;
         if (e == 15) check("abort_busy_before", 64'(bus.busy), 64'd1);
         if (e == 16) begin
            check("abort_busy", 64'(bus.busy), 64'd0);
            check("abort_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
         end
         if (e > 16 && bus.busy) busy_n++;
         reset = (e == 15);
      end
      reset = 1'b0;
      check("abort_no_done", 64'(done_n), 64'd0);
      check("abort_idle", 64'(busy_n), 64'd0);
      last_prod = '0;
      do_op(32'd2, 32'd3, 1'b0, -1);
      check("vec_after_abort", {bus.prod_hi, bus.prod_lo}, 64'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
